// File: rtl/tick_period_monitor.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tick_period_monitor: checks tick spacing against EXP_CYCLES +/- TOL,       |
// | reports early/late errors and lock, counts ticks. Rev 1.0                 |
// +---------------------------------------------------------------------------+
module tick_period_monitor #(
  parameter int EXP_CYCLES = 521,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic [7:0]       tick_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  LO_LIM  = CNT_W'(EXP_CYCLES - TOL);
  localparam logic [CNT_W-1:0]  HI_LIM  = CNT_W'(EXP_CYCLES + TOL);
  localparam logic [CNT_W-1:0]  THR     = CNT_W'(EXP_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;

  logic [CNT_W-1:0]  period_nxt;
  logic              period_valid_nxt;
  logic              locked_nxt;
  logic              err_early_nxt;
  logic              err_late_nxt;
  logic [7:0]        tick_count_nxt;

  logic active;
  logic in_tol;
  logic at_thr;

  assign active = (state == S_ACQUIRE) || (state == S_LOCKED);
  assign in_tol = (cnt >= LO_LIM) && (cnt <= HI_LIM);
  assign at_thr = (cnt == THR);

  // State register: every output is registered alongside the FSM state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_early    <= 1'b0;
      err_late     <= 1'b0;
      tick_count   <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      good_cnt     <= good_nxt;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
      locked       <= locked_nxt;
      err_early    <= err_early_nxt;
      err_late     <= err_late_nxt;
      tick_count   <= tick_count_nxt;
    end
  end

  // Next-state logic; a missing tick at THR drops lock without a capture
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      S_IDLE: begin
        good_nxt = '0;
        if (tick_in) state_nxt = S_ACQUIRE;
      end
      S_ACQUIRE, S_LOCKED: begin
        if (tick_in) begin
          if (in_tol) begin
            if (state == S_ACQUIRE) begin
              good_nxt = good_cnt + 1'b1;
              if (good_cnt + 1'b1 == GOOD_TARGET) state_nxt = S_LOCKED;
            end
          end else begin
            good_nxt  = '0;
            state_nxt = S_ACQUIRE;
          end
        end else if (at_thr) begin
          good_nxt  = '0;
          state_nxt = S_ACQUIRE;
        end
      end
      default: begin
        good_nxt  = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    period_nxt       = period;
    period_valid_nxt = 1'b0;
    err_early_nxt    = 1'b0;
    err_late_nxt     = 1'b0;
    locked_nxt       = (state_nxt == S_LOCKED);
    tick_count_nxt   = tick_in ? tick_count + 8'd1 : tick_count;

    if (tick_in)
      cnt_nxt = CNT_W'(1);
    else if (active)
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    else
      cnt_nxt = '0;

    if (active) begin
      err_late_nxt = at_thr;
      if (tick_in) begin
        period_nxt       = cnt;
        period_valid_nxt = 1'b1;
        err_early_nxt    = (cnt < LO_LIM);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_tick_period_monitor: directed self-checking bench. Rev 1.0             |
// +---------------------------------------------------------------------------+
module tb_tick_period_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        tick_s = 1'b0;

  logic [15:0] period;
  logic        period_valid, locked, err_early, err_late;
  logic [7:0]  tick_count;

  logic [9:0]  period_s;
  logic        period_valid_s, locked_s, err_early_s, err_late_s;
  logic [7:0]  tick_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tick_period_monitor #(.EXP_CYCLES(521), .TOL(2), .LOCK_COUNT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in),
    .period(period), .period_valid(period_valid), .locked(locked),
    .err_early(err_early), .err_late(err_late), .tick_count(tick_count)
  );

  tick_period_monitor #(.EXP_CYCLES(521), .TOL(2), .LOCK_COUNT(4), .CNT_W(10)) dut_s (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_s),
    .period(period_s), .period_valid(period_valid_s), .locked(locked_s),
    .err_early(err_early_s), .err_late(err_late_s), .tick_count(tick_count_s)
  );

  // One clock: drive tick_in, then observe 1 time unit after the edge
  task automatic cycle(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
    tick_in = 1'b0;
  endtask

  // n tick-free cycles; position i equals the distance from the last tick
  task automatic quiet(input int n, output int late_n, output int late_at,
                       output int pv_n, output int early_n, output int unlock_at);
    late_n = 0; late_at = 0; pv_n = 0; early_n = 0; unlock_at = 0;
    for (int i = 1; i <= n; i++) begin
      cycle(1'b0);
      if (err_late) begin late_n++; if (late_at == 0) late_at = i; end
      if (period_valid) pv_n++;
      if (err_early) early_n++;
      if (!locked && unlock_at == 0) unlock_at = i;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({period, period_valid, locked, err_early, err_late, tick_count} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got period=%0d pv=%0b lk=%0b ee=%0b el=%0b tc=%0d required all 0",
               period, period_valid, locked, err_early, err_late, tick_count);
    end
  endtask

  task automatic test_acquire_lock();
    int ln, la, pn, en, ua;
    cycle(1'b1);
    n_checks++;
    if (period_valid !== 1'b0 || tick_count !== 8'd1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL first_tick: got pv=%0b tc=%0d lk=%0b required pv=0 tc=1 lk=0",
               period_valid, tick_count, locked);
    end
    for (int k = 2; k <= 5; k++) begin
      quiet(520, ln, la, pn, en, ua);
      cycle(1'b1);
      n_checks++;
      if (period_valid !== 1'b1 || period !== 16'd521 || locked !== (k == 5) ||
          err_early !== 1'b0 || err_late !== 1'b0 || tick_count !== 8'(k) ||
          ln != 0 || pn != 0 || en != 0) begin
        n_fail++;
        $display("FAIL lock_tick%0d: got pv=%0b per=%0d lk=%0b ee=%0b el=%0b tc=%0d qlate=%0d qpv=%0d required pv=1 per=521 lk=%0b no errors tc=%0d",
                 k, period_valid, period, locked, err_early, err_late, tick_count, ln, pn, k == 5, k);
      end
    end
  endtask

  task automatic test_tolerance();
    int ln, la, pn, en, ua;
    int gaps[3] = '{519, 523, 518};
    for (int g = 0; g < 3; g++) begin
      quiet(gaps[g] - 1, ln, la, pn, en, ua);
      cycle(1'b1);
      n_checks++;
      if (period !== 16'(gaps[g]) || period_valid !== 1'b1 || locked !== (g != 2) ||
          err_early !== (g == 2) || err_late !== 1'b0) begin
        n_fail++;
        $display("FAIL tol_gap%0d: got per=%0d pv=%0b lk=%0b ee=%0b el=%0b required per=%0d pv=1 lk=%0b ee=%0b el=0",
                 gaps[g], period, period_valid, locked, err_early, err_late, gaps[g], g != 2, g == 2);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      quiet(520, ln, la, pn, en, ua);
      cycle(1'b1);
      n_checks++;
      if (locked !== (k == 4)) begin
        n_fail++;
        $display("FAIL relock_after_early%0d: got lk=%0b required %0b", k, locked, k == 4);
      end
    end
  endtask

  task automatic test_timeout();
    int ln, la, pn, en, ua;
    quiet(599, ln, la, pn, en, ua);
    n_checks++;
    if (ln != 1 || la != 524 || ua != 524 || pn != 0) begin
      n_fail++;
      $display("FAIL timeout_late: got count=%0d at=%0d unlock_at=%0d pv=%0d required count=1 at=524 unlock_at=524 pv=0",
               ln, la, ua, pn);
    end
    cycle(1'b1);
    n_checks++;
    if (period !== 16'd600 || period_valid !== 1'b1 || err_late !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_capture: got per=%0d pv=%0b el=%0b lk=%0b required per=600 pv=1 el=0 lk=0",
               period, period_valid, err_late, locked);
    end
    for (int k = 1; k <= 4; k++) begin
      quiet(520, ln, la, pn, en, ua);
      cycle(1'b1);
    end
    n_checks++;
    if (locked !== 1'b1 || period !== 16'd521) begin
      n_fail++;
      $display("FAIL timeout_relock: got lk=%0b per=%0d required lk=1 per=521", locked, period);
    end
  endtask

  task automatic test_tick_at_thr();
    int ln, la, pn, en, ua;
    quiet(523, ln, la, pn, en, ua);
    n_checks++;
    if (ln != 0 || ua != 0) begin
      n_fail++;
      $display("FAIL thr_pre: got late=%0d unlock_at=%0d required 0 0", ln, ua);
    end
    cycle(1'b1);
    n_checks++;
    if (period !== 16'd524 || period_valid !== 1'b1 || err_late !== 1'b1 ||
        err_early !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_capture: got per=%0d pv=%0b el=%0b ee=%0b lk=%0b required per=524 pv=1 el=1 ee=0 lk=0",
               period, period_valid, err_late, err_early, locked);
    end
    cycle(1'b0);
    n_checks++;
    if (err_late !== 1'b0 || period_valid !== 1'b0 || period !== 16'd524) begin
      n_fail++;
      $display("FAIL thr_pulse_end: got el=%0b pv=%0b per=%0d required el=0 pv=0 per=524",
               err_late, period_valid, period);
    end
  endtask

  task automatic test_mid_reset();
    int ln, la, pn, en, ua;
    cycle(1'b1);  // distance 2: early, restarts acquisition
    n_checks++;
    if (err_early !== 1'b1 || period !== 16'd2) begin
      n_fail++;
      $display("FAIL short_gap: got ee=%0b per=%0d required ee=1 per=2", err_early, period);
    end
    for (int k = 1; k <= 4; k++) begin
      quiet(520, ln, la, pn, en, ua);
      cycle(1'b1);
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL prereset_lock: got lk=%0b required 1", locked);
    end
    quiet(200, ln, la, pn, en, ua);
    reset_n = 1'b0;
    cycle(1'b0);
    n_checks++;
    if ({period, period_valid, locked, err_early, err_late, tick_count} !== 28'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got per=%0d pv=%0b lk=%0b ee=%0b el=%0b tc=%0d required all 0",
               period, period_valid, locked, err_early, err_late, tick_count);
    end
    cycle(1'b1);
    n_checks++;
    if (tick_count !== 8'd0 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_in_reset: got tc=%0d pv=%0b required tc=0 pv=0", tick_count, period_valid);
    end
    reset_n = 1'b1;
    cycle(1'b1);
    n_checks++;
    if (period_valid !== 1'b0 || tick_count !== 8'd1 || period !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_first: got pv=%0b tc=%0d per=%0d required pv=0 tc=1 per=0",
               period_valid, tick_count, period);
    end
    quiet(520, ln, la, pn, en, ua);
    cycle(1'b1);
    n_checks++;
    if (period_valid !== 1'b1 || period !== 16'd521 || locked !== 1'b0 || err_early !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_second: got pv=%0b per=%0d lk=%0b ee=%0b required pv=1 per=521 lk=0 ee=0",
               period_valid, period, locked, err_early);
    end
  endtask

  // Short spacing keeps the run bounded; tick_count counts ticks regardless of spacing
  task automatic test_count_wrap();
    int ln, la, pn, en, ua;
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      quiet(3, ln, la, pn, en, ua);
      cycle(1'b1);
      if (k == 1 || k == 255 || k == 256) begin
        n_checks++;
        if (tick_count !== 8'(k)) begin
          n_fail++;
          $display("FAIL tick_count_%0d: got %0d required %0d", k, tick_count, k % 256);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int late_n = 0;
    int late_at = 0;
    tick_s = 1'b1;
    @(posedge clk); #1;
    tick_s = 1'b0;
    for (int i = 1; i < 1500; i++) begin
      @(posedge clk); #1;
      if (err_late_s) begin late_n++; if (late_at == 0) late_at = i; end
    end
    tick_s = 1'b1;
    @(posedge clk); #1;
    tick_s = 1'b0;
    n_checks++;
    if (period_s !== 10'd1023 || period_valid_s !== 1'b1 || err_late_s !== 1'b0 ||
        late_n != 1 || late_at != 524) begin
      n_fail++;
      $display("FAIL saturation: got per=%0d pv=%0b el=%0b late_count=%0d late_at=%0d required per=1023 pv=1 el=0 late_count=1 late_at=524",
               period_s, period_valid_s, err_late_s, late_n, late_at);
    end
  endtask

  initial begin
    test_reset();
    test_acquire_lock();
    test_tolerance();
    test_timeout();
    test_tick_at_thr();
    test_mid_reset();
    test_count_wrap();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
